// File: rtl/ram_port_a_burst_ctrl.sv
// Port-A burst sequencer for a 512x8 true dual-port RAM.
// Turns one burst command into consecutive byte writes or reads.
module ram_port_a_burst_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 10
) (
    input  logic              clk_a,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              done,
    output logic              busy,
    output logic              wren_a,
    output logic              rden_a,
    output logic [ADDR_W-1:0] address_a,
    output logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] q_a
);

    localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0]  rem;
    logic              rd_pend;

    always_ff @(posedge clk_a) begin
        if (rst) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            rem      <= '0;
            rd_pend  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            // q_a is valid the cycle after a read issue; capture it then
            rd_pend  <= (state == S_READ);
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= q_a;
            end
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_addr <= cmd_addr;
                        rem      <= (cmd_len > DEPTH) ? DEPTH : cmd_len;
                        if (cmd_len == '0) begin
                            state <= S_DONE;
                        end else if (cmd_write) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_valid) begin
                        cur_addr <= cur_addr + ADDR_W'(1);
                        rem      <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                    rem      <= rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // last byte is on rd_valid once nothing is pending
                    if (!rd_pend) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        wr_ready  = 1'b0;
        wren_a    = 1'b0;
        rden_a    = 1'b0;
        address_a = '0;
        data_a    = '0;
        if (state == S_WRITE) begin
            wr_ready  = 1'b1;
            wren_a    = wr_valid;
            address_a = cur_addr;
            data_a    = wr_data;
        end
        if (state == S_READ) begin
            rden_a    = 1'b1;
            address_a = cur_addr;
        end
    end

endmodule

// File: tb/tb_ram_port_a_burst_ctrl.sv
// Bench for ram_port_a_burst_ctrl with a behavioural RAM on port A.
// Expected writes and read bytes go through scoreboard queues.
module tb_ram_port_a_burst_ctrl;

    localparam int AW    = 9;
    localparam int DW    = 8;
    localparam int LW    = 10;
    localparam int DEPTH = 512;

    logic          clk_a = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          done;
    logic          busy;
    logic          wren_a;
    logic          rden_a;
    logic [AW-1:0] address_a;
    logic [DW-1:0] data_a;
    logic [DW-1:0] q_a = '0;

    always #5 clk_a = ~clk_a;

    ram_port_a_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk_a(clk_a), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .done(done), .busy(busy),
        .wren_a(wren_a), .rden_a(rden_a),
        .address_a(address_a), .data_a(data_a), .q_a(q_a)
    );

    // RAM port A: registered read, one cycle latency
    logic [DW-1:0] mem [DEPTH] = '{default: 8'h00};
    always @(posedge clk_a) begin
        if (wren_a) mem[address_a] <= data_a;
        if (rden_a) q_a <= mem[address_a];
    end

    logic [DW-1:0] ref_mem [DEPTH] = '{default: 8'h00};
    logic [16:0]   wexp_q[$];
    logic [7:0]    rexp_q[$];
    logic [7:0]    byte_q[$];
    int            n_pass = 0;
    int            n_chk = 0;
    logic [16:0]   mon_w;
    logic [7:0]    mon_r;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    always @(negedge clk_a) begin
        if (wren_a) begin
            if (wexp_q.size() == 0) begin
                chk("unexpected_write", 32'(address_a), 32'hFFFF);
            end else begin
                mon_w = wexp_q.pop_front();
                chk("wr_addr", 32'(address_a), 32'(mon_w[16:8]));
                chk("wr_data", 32'(data_a), 32'(mon_w[7:0]));
            end
        end
        if (rd_valid) begin
            if (rexp_q.size() == 0) begin
                chk("unexpected_rd_valid", 32'(rd_data), 32'hFFFF);
            end else begin
                mon_r = rexp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(mon_r));
            end
        end
    end

    task automatic issue_cmd(input logic wr, input logic [AW-1:0] a,
                             input logic [LW-1:0] n);
        int t;
        t = 0;
        @(posedge clk_a); #1;
        while (!cmd_ready && t < 2000) begin
            @(posedge clk_a); #1;
            t++;
        end
        chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = n;
        @(posedge clk_a); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] n,
                            input bit rnd, input int stall_at);
        int eff, i, t, nw, bad, t_acc, t_done;
        bit v, stalled;
        eff = (int'(n) > DEPTH) ? DEPTH : int'(n);
        for (int k = 0; k < eff; k++) begin
            wexp_q.push_back({9'(int'(a) + k), byte_q[k]});
            ref_mem[9'(int'(a) + k)] = byte_q[k];
        end
        issue_cmd(1'b1, a, n);
        i = 0; nw = 0; bad = 0; t_acc = -1; t_done = -1; stalled = 0;
        for (t = 0; t < 5000 && t_done < 0; t++) begin
            v = (i < eff);
            if (v && rnd && $urandom_range(0, 3) == 0) v = 0;
            if (v && !rnd && i == stall_at && !stalled) begin
                v = 0;
                stalled = 1;
            end
            wr_valid = v;
            wr_data  = v ? byte_q[i] : 8'($urandom);
            @(negedge clk_a);
            if (wren_a) nw++;
            if (wren_a && !v) bad++;
            if (v && !wr_ready) bad++;
            if (done) t_done = t;
            @(posedge clk_a); #1;
            if (v) begin
                i++;
                t_acc = t;
            end
        end
        wr_valid = 1'b0;
        chk("wr_count", 32'(nw), 32'(eff));
        chk("wr_stall_or_ready", 32'(bad), 32'd0);
        chk("wr_done_timing", 32'(t_done), 32'(t_acc + 1));
        chk("wr_queue_drained", 32'(wexp_q.size()), 32'd0);
        @(negedge clk_a);
        chk("wr_idle_after", 32'({cmd_ready, busy, done}), 32'b100);
        byte_q.delete();
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] n);
        int eff, t, t_ren, t_rv, t_last, t_done, nv, nren;
        eff = (int'(n) > DEPTH) ? DEPTH : int'(n);
        for (int k = 0; k < eff; k++) rexp_q.push_back(ref_mem[9'(int'(a) + k)]);
        issue_cmd(1'b0, a, n);
        t_ren = -1; t_rv = -1; t_last = -1; t_done = -1; nv = 0; nren = 0;
        for (t = 0; t < 2000 && t_done < 0; t++) begin
            @(negedge clk_a);
            if (rden_a) begin
                nren++;
                if (t_ren < 0) t_ren = t;
            end
            if (rd_valid) begin
                nv++;
                if (t_rv < 0) t_rv = t;
                t_last = t;
            end
            if (done) t_done = t;
        end
        chk("rd_issue_count", 32'(nren), 32'(eff));
        chk("rd_valid_count", 32'(nv), 32'(eff));
        if (eff > 0) begin
            chk("rd_latency", 32'(t_rv - t_ren), 32'd2);
            chk("rd_consecutive", 32'(t_last - t_rv), 32'(eff - 1));
            chk("rd_done_timing", 32'(t_done), 32'(t_last + 1));
        end else begin
            chk("rd_len0_done", 32'(t_done), 32'd0);
        end
        chk("rd_queue_drained", 32'(rexp_q.size()), 32'd0);
        @(negedge clk_a);
        chk("rd_idle_after", 32'({cmd_ready, busy, done}), 32'b100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ra;
        logic [LW-1:0] rn;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 0; wr_data = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk_a);
        @(negedge clk_a);
        chk("reset_state", {cmd_ready, busy, done, rd_valid, wr_ready, wren_a,
            rden_a, rd_data, address_a, data_a}, {1'b1, 31'b0});
        @(posedge clk_a); #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_a);
            chk("idle_cycle", {cmd_ready, busy, done, rd_valid, wr_ready, wren_a,
                rden_a, rd_data, address_a, data_a}, {1'b1, 31'b0});
        end

        byte_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_write(9'h010, 10'd4, 1'b0, 2);
        do_read(9'h010, 10'd4);

        byte_q = '{8'h11, 8'h22, 8'h33};
        do_write(9'h1FE, 10'd3, 1'b0, -1);
        do_read(9'h1FE, 10'd3);

        // zero-length command, with a second command held during DONE
        @(posedge clk_a); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 9'h005; cmd_len = '0;
        @(posedge clk_a); #1;
        cmd_write = 1'b1; cmd_len = 10'd1; wr_valid = 1'b1; wr_data = 8'h5A;
        @(negedge clk_a);
        chk("len0_done", 32'({done, busy, cmd_ready, rden_a, wren_a}), 32'b11000);
        @(posedge clk_a); #1;
        cmd_valid = 1'b0; wr_valid = 1'b0;
        @(negedge clk_a);
        chk("busy_cmd_ignored", 32'({done, busy, cmd_ready, wren_a, rden_a}), 32'b00100);
        do_read(9'h033, 10'd0);

        // reset during the second cycle of an 8-byte read
        issue_cmd(1'b0, 9'h010, 10'd8);
        @(posedge clk_a); #1;
        rst = 1'b1;
        @(posedge clk_a); #1;
        rst = 1'b0;
        @(negedge clk_a);
        chk("rst_abort", 32'({rd_valid, done, cmd_ready, rden_a, busy}), 32'b00100);
        repeat (4) @(negedge clk_a);
        do_read(9'h1FE, 10'd3);

        for (int r = 0; r < 6; r++) begin
            ra = 9'($urandom);
            rn = 10'($urandom_range(1, 40));
            for (int k = 0; k < int'(rn); k++) byte_q.push_back(8'($urandom));
            do_write(ra, rn, 1'b1, -1);
            do_read(9'(int'(ra) + $urandom_range(0, 5)), 10'($urandom_range(1, 40)));
        end

        // oversize length truncates to a full-memory burst
        for (int k = 0; k < DEPTH; k++) byte_q.push_back(8'($urandom));
        do_write(9'h100, 10'd700, 1'b1, -1);
        do_read(9'h000, 10'd512);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
